// File: rtl/display_scheduler.sv
`default_nettype none
// display_scheduler: round-robin time-sharing of a 7-segment display's number input.
// Each slot shows one source's captured value for DWELL_CYCLES clocks, then an optional blank gap follows.
module display_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 50000000,
  parameter int BLANK_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     req,
  input  logic [16*NUM_SRC-1:0]  data,
  input  logic                   freeze,
  output logic [NUM_SRC-1:0]     grant,
  output logic                   done,
  output logic [15:0]            number,
  output logic                   number_valid
);

  localparam int CW = $clog2(DWELL_CYCLES + 1);
  localparam int GW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam int PW = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [GW-1:0]       gcnt, gcnt_nxt;
  logic [PW-1:0]       ptr, ptr_nxt;
  logic [NUM_SRC-1:0]  grant_nxt;
  logic [15:0]         number_nxt;
  logic                valid_nxt;

  logic [NUM_SRC-1:0]  cand;
  logic [NUM_SRC-1:0]  win_onehot;
  logic [PW-1:0]       win;
  logic [PW:0]         idx;
  logic                found;
  logic                take;

  assign done = (state == SHOW) && (cnt == CW'(DWELL_CYCLES - 1)) && !freeze;

  // Back-to-back slots exclude the finishing owner for the handover edge only.
  always_comb begin
    cand       = (state == SHOW && BLANK_CYCLES == 0) ? (req & ~grant) : req;
    found      = 1'b0;
    win        = '0;
    idx        = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NUM_SRC)) begin
        idx = idx - (PW+1)'(NUM_SRC);
      end
      if (!found && cand[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
    win_onehot      = '0;
    win_onehot[win] = 1'b1;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    gcnt_nxt   = gcnt;
    ptr_nxt    = ptr;
    grant_nxt  = grant;
    number_nxt = number;
    valid_nxt  = number_valid;
    take       = 1'b0;
    case (state)
      IDLE: take = found;
      SHOW: begin
        if (done) begin
          cnt_nxt = '0;
          if (BLANK_CYCLES > 0) begin
            state_nxt = GAP;
            grant_nxt = '0;
            valid_nxt = 1'b0;
            gcnt_nxt  = '0;
          end else if (found) begin
            take = 1'b1;
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
            valid_nxt = 1'b0;
          end
        end else if (!freeze) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      GAP: begin
        if (gcnt == GW'(BLANK_CYCLES - 1)) begin
          if (found) take = 1'b1;
          else state_nxt = IDLE;
        end else begin
          gcnt_nxt = gcnt + GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (take) begin
      state_nxt  = SHOW;
      grant_nxt  = win_onehot;
      number_nxt = data[16*win +: 16];
      valid_nxt  = 1'b1;
      cnt_nxt    = '0;
      ptr_nxt    = (win == PW'(NUM_SRC - 1)) ? '0 : win + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      gcnt         <= '0;
      ptr          <= '0;
      grant        <= '0;
      number       <= 16'h0000;
      number_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      gcnt         <= gcnt_nxt;
      ptr          <= ptr_nxt;
      grant        <= grant_nxt;
      number       <= number_nxt;
      number_valid <= valid_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// tb_display_scheduler: scoreboard bench driving a BLANK=2 and a BLANK=0 scheduler with shared stimulus.
module tb_display_scheduler;

  localparam int DW = 5;

  typedef struct {
    int          src;
    logic [15:0] val;
    int          dead;
  } start_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_d = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [63:0] data = 64'h0;
  logic        freeze = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rst_d <= rst;

  task automatic check(input int inst, input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL [inst %0d] %s: got %0h expected %0h at %0t", inst, name, act, exp, $time);
    end
  endtask

  // First requesting source at or after p, wrapping; -1 when nobody asks.
  function automatic int arb(input logic [3:0] c, input int p);
    for (int k = 0; k < 4; k++) begin
      if (c[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int BL = (g == 0) ? 2 : 0;

    logic [3:0]  grant;
    logic        done;
    logic [15:0] number;
    logic        valid;

    display_scheduler #(
      .NUM_SRC(4), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)
    ) dut (
      .clk(clk), .rst(rst), .req(req), .data(data), .freeze(freeze),
      .grant(grant), .done(done), .number(number), .number_valid(valid)
    );

    start_t exp_start[$];
    int     exp_len[$];

    // Reference: slot-level bookkeeping with plain counters.
    int m_st = 0, m_ptr = 0, m_cnt = 0, m_tot = 0, m_gap = 0, m_dead = 0, m_owner = 0;
    always @(posedge clk) begin : model
      int w;
      if (rst) begin
        m_st   = 0;
        m_ptr  = 0;
        m_dead = 0;
      end else begin
        w = -1;
        case (m_st)
          0: w = arb(req, m_ptr);
          1: begin
            m_tot++;
            if (!freeze) m_cnt++;
            if (m_cnt == DW) begin
              exp_len.push_back(m_tot);
              if (BL > 0) begin
                m_st  = 2;
                m_gap = 0;
              end else begin
                w = arb(req & ~(4'b0001 << m_owner), m_ptr);
                if (w < 0) m_st = 0;
              end
            end
          end
          default: begin
            m_gap++;
            if (m_gap == BL) begin
              w = arb(req, m_ptr);
              if (w < 0) m_st = 0;
            end
          end
        endcase
        if (w >= 0) begin
          exp_start.push_back('{w, data[16*w +: 16], m_dead});
          m_owner = w;
          m_ptr   = (w + 1) % 4;
          m_st    = 1;
          m_cnt   = 0;
          m_tot   = 0;
          m_dead  = 0;
        end
      end
      if (m_st != 1) m_dead++;
    end

    bit          in_slot = 1'b0;
    bit          prev_done = 1'b0;
    int          len = 0;
    int          dcount = 0;
    logic [3:0]  cur_grant = 4'b0;
    logic [15:0] cur_val = 16'h0;
    logic [15:0] last_val = 16'h0;

    always @(negedge clk) begin : monitor
      start_t s;
      if (rst_d) begin
        check(g, "rst_grant", grant, 0);
        check(g, "rst_number", number, 0);
        check(g, "rst_valid", valid, 0);
        in_slot   = 1'b0;
        prev_done = 1'b0;
        dcount    = 1;
        last_val  = 16'h0;
      end else begin
        if (prev_done) begin
          if (exp_len.size() == 0) check(g, "len_queue_empty", 0, 1);
          else check(g, "slot_len", len, exp_len.pop_front());
          in_slot = 1'b0;
        end
        check(g, "valid_vs_grant", (grant != 0), valid);
        check(g, "grant_onehot", ($countones(grant) <= 1), 1);
        if (grant != 0 && !in_slot) begin
          if (exp_start.size() == 0) begin
            check(g, "unexpected_slot", 0, 1);
            cur_grant = grant;
            cur_val   = number;
          end else begin
            s = exp_start.pop_front();
            cur_grant = 4'b0001 << s.src;
            cur_val   = s.val;
            check(g, "slot_owner", grant, cur_grant);
            check(g, "slot_number", number, s.val);
            check(g, "dead_cycles", dcount, s.dead);
          end
          last_val = cur_val;
          in_slot  = 1'b1;
          len      = 0;
          dcount   = 0;
        end
        if (in_slot) begin
          if (!valid) begin
            check(g, "slot_abort", 0, 1);
            in_slot = 1'b0;
          end else begin
            len++;
            check(g, "hold_number", number, cur_val);
            check(g, "hold_grant", grant, cur_grant);
            if (len > 300) begin
              check(g, "slot_timeout", len, 0);
              in_slot = 1'b0;
            end
          end
        end else begin
          dcount++;
          check(g, "idle_number", number, last_val);
        end
        if (done) check(g, "done_in_slot", in_slot, 1);
        prev_done = done;
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      data = {$urandom, $urandom};
    end
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // Single request from source 1.
    req = 4'b0010;
    data[31:16] = 16'h1234;
    @(posedge clk);
    #1;
    req = 4'b0000;
    cyc(14);

    // Everyone asks; round-robin over all four.
    req = 4'b1111;
    cyc(40);

    // Freeze for three clocks in the middle of a slot.
    freeze = 1'b1;
    cyc(3);
    freeze = 1'b0;
    cyc(20);

    req = 4'b0101;
    cyc(30);
    req = 4'b0001;
    cyc(20);

    // Reset mid-slot, then everyone requests.
    req = 4'b1111;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(20);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom);
      freeze = ($urandom_range(0, 7) == 0);
      rst    = ($urandom_range(0, 399) == 0);
      cyc(1);
    end

    rst    = 1'b0;
    freeze = 1'b0;
    req    = 4'b0000;
    cyc(60);

    check(0, "end_start_queue", g_inst[0].exp_start.size(), 0);
    check(0, "end_len_queue", g_inst[0].exp_len.size(), 0);
    check(1, "end_start_queue", g_inst[1].exp_start.size(), 0);
    check(1, "end_len_queue", g_inst[1].exp_len.size(), 0);
    check(0, "end_idle", g_inst[0].in_slot, 0);
    check(1, "end_idle", g_inst[1].in_slot, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
Time-shares the 16-bit value input of the 4-digit multiplexed 7-segment display between NUM_SRC requesters. Round-robin arbitration picks one requester per slot, captures its value and holds it steady for DWELL_CYCLES clocks, then optionally blanks for BLANK_CYCLES clocks before the next slot. It sits between the application sources and the 4-digit display driver's number input. number_valid gates the display's digit-select lines.

Parameters:
NUM_SRC, 4, number of requesters; legal range 2..8.
DWELL_CYCLES, 50000000, clocks each granted value is shown; must be >= 1.
BLANK_CYCLES, 0, blank clocks between slots; 0 means slots run back-to-back.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
req  input  NUM_SRC  per-source slot request; level-sensitive.
data  input  16*NUM_SRC  packed values; source i occupies bits [16*i+15:16*i].
freeze  input  1  while high, stalls the SHOW dwell counter.
grant  output  NUM_SRC  one-hot owner of the current slot; all zeros outside SHOW.
done  output  1  high during the final clock of a slot.
number  output  16  value to display; feeds the display driver's number input.
number_valid  output  1  high only in SHOW; when low, downstream blanks the digits.

Behaviour:
- All state and outputs are registered except done. done = (state==SHOW) && (cnt==DWELL_CYCLES-1) && !freeze.
- Reset, sampled on the clk edge with rst=1, overrides everything, including mid-slot:
  - state=IDLE, grant=0, number=16'h0000, number_valid=0, cnt=0.
  - Round-robin pointer ptr=0.
- State IDLE:
  - If any req bit is high on an edge, that edge loads state=SHOW.
  - grant=onehot(w), where w is the first set req bit searching ptr, ptr+1, ... with wrap.
  - number=data slice w, captured once; number_valid=1, cnt=0, ptr=(w+1) mod NUM_SRC.
  - Latency is 1 clock from req high to grant high.
- State SHOW:
  - cnt increments by 1 on each edge with freeze=0 and holds when freeze=1.
  - number is held constant for the whole slot. Changes on data and dropping req do not abort or alter the slot.
  - On the edge where done=1, the slot ends:
    - If BLANK_CYCLES>0: state=GAP, grant=0, number_valid=0, gap counter=0.
    - If BLANK_CYCLES==0: arbitrate over req & ~grant. The finishing owner is masked for this edge only. If a winner exists, enter a new SHOW with a new capture and cnt=0, with no dead cycle. If there is no winner, go to IDLE.
- State GAP:
  - Lasts exactly BLANK_CYCLES clocks; freeze has no effect here.
  - On the last GAP edge, arbitrate over all req bits with no mask. A winner enters SHOW, as from IDLE. No winner goes to IDLE.
- number retains its last captured value in IDLE and GAP; only number_valid drops.
- A sole requester holding req=1:
  - BLANK_CYCLES==0: masked at slot end, goes to IDLE for 1 clock, then is regranted.
  - BLANK_CYCLES>0: regranted directly after the GAP.
- cnt width is $clog2(DWELL_CYCLES+1), so there is no overflow. DWELL_CYCLES=1 means done is high on the first SHOW clock when freeze=0.
- grant is never multi-hot. grant!=0 if and only if number_valid=1.

Test Plan:
All tests use NUM_SRC=4, DWELL_CYCLES=5, BLANK_CYCLES=2 unless stated.
1. Reset, then req=4'b0010, data slice1=16'h1234 -> one clock later grant=0010, number=1234, number_valid=1. done is high on the 5th SHOW clock. Then 2 clocks of grant=0, number_valid=0.
2. req=4'b1111 held, distinct values per source -> grants in the order 0001, 0010, 0100, 1000, 0001. Each SHOW lasts 5 clocks, separated by 2-clock gaps.
3. During SHOW, change the owner's data and drop its req -> number is unchanged and the slot still lasts 5 clocks.
4. freeze=1 for 3 clocks mid-slot -> the slot lasts 8 clocks, done is high only on the final clock, and the GAP length is unaffected.
5. BLANK_CYCLES=0, req=4'b0101 -> back-to-back slots src0, src2, src0 with no number_valid drop. Sole requester req=0001 -> IDLE for 1 clock between slots.
6. Assert rst=1 for one clock mid-SHOW -> the next clock shows grant=0, number=0, number_valid=0. With req=1111 afterwards, src0 wins first (ptr reset to 0).
